// File: rtl/qos_latency_monitor.sv
// qos_latency_monitor: passive per-core request/response latency monitor feeding QoS status counters.
// Per-level EMA average latency is built only when QOS_MON_AVG_LATENCY_EN is defined.
module qos_latency_monitor #(
    parameter int NUM_CORES      = 4,
    parameter int NUM_QOS_LEVELS = 16,
    parameter int AVG_SHIFT      = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_CORES-1:0]                req_fire_i,
    input  logic [NUM_CORES-1:0]                rsp_fire_i,
    input  logic [NUM_CORES-1:0][3:0]           qos_level_i,
    input  logic [NUM_CORES-1:0][15:0]          latency_limit_i,
    input  logic                                monitor_enable_i,
    input  logic                                clear_counters_i,
    output logic [31:0]                         qos_violations_o,
    output logic [31:0]                         total_requests_o,
    output logic [NUM_QOS_LEVELS-1:0][31:0]     qos_hit_counts_o,
    output logic [NUM_QOS_LEVELS-1:0][31:0]     qos_miss_counts_o,
    output logic [NUM_QOS_LEVELS-1:0][31:0]     avg_latencies_o,
    output logic [NUM_CORES-1:0]                inflight_overrun_o,
    output logic                                protocol_err_o
);
    typedef enum logic {IDLE, WAIT} state_t;

    logic [NUM_CORES-1:0]       comp, miss, issue, err;
    logic [NUM_CORES-1:0][3:0]  lvl;
    logic [NUM_CORES-1:0][16:0] lat;
    logic [31:0]                viol_q, req_q;
    logic                       err_q;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [31:0] popcnt(input logic [NUM_CORES-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < NUM_CORES; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    genvar c, l;
    generate
        for (c = 0; c < NUM_CORES; c++) begin : g_core
            state_t      state_q;
            logic [15:0] cnt_q, lim_q;
            logic [3:0]  lvl_q;
            logic        idle, over;
            assign idle = state_q == IDLE;
            assign lat[c] = {1'b0, cnt_q} + 17'd1;
            assign lvl[c] = lvl_q;
            assign over = lat[c] > {1'b0, lim_q};
            assign comp[c] = !idle && rsp_fire_i[c];
            // A request while waiting is only legal when the same cycle retires the old one
            assign issue[c] = req_fire_i[c] && (idle || rsp_fire_i[c]);
            assign err[c] = idle ? rsp_fire_i[c] : req_fire_i[c] && !rsp_fire_i[c];
            assign miss[c] = comp[c] && over;
            assign inflight_overrun_o[c] = !idle && over;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    lvl_q   <= '0;
                    lim_q   <= '0;
                end else if (issue[c]) begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                    lvl_q   <= qos_level_i[c];
                    lim_q   <= latency_limit_i[c];
                end else if (comp[c]) begin
                    state_q <= IDLE;
                end else if (!idle && cnt_q != 16'hFFFF) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end

        for (l = 0; l < NUM_QOS_LEVELS; l++) begin : g_lvl
            logic [31:0]          hit_q, miss_q, hit_add, miss_add;
            logic [NUM_CORES-1:0] on_lvl;
            always_comb begin
                on_lvl   = '0;
                hit_add  = '0;
                miss_add = '0;
                for (int i = 0; i < NUM_CORES; i++) begin
                    on_lvl[i] = comp[i] && lvl[i] == 4'(l);
                    hit_add   = hit_add + 32'(on_lvl[i] && !miss[i]);
                    miss_add  = miss_add + 32'(on_lvl[i] && miss[i]);
                end
            end
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i || clear_counters_i) begin
                    hit_q  <= '0;
                    miss_q <= '0;
                end else if (monitor_enable_i) begin
                    hit_q  <= sat_add(hit_q, hit_add);
                    miss_q <= sat_add(miss_q, miss_add);
                end
            end
            assign qos_hit_counts_o[l]  = hit_q;
            assign qos_miss_counts_o[l] = miss_q;
`ifdef QOS_MON_AVG_LATENCY_EN
            logic [31:0]        avg_q;
            logic               seen_q, s_vld;
            logic [16:0]        s_lat;
            logic signed [32:0] diff, step;
            // Reverse scan so the lowest-index completing core supplies the sample
            always_comb begin
                s_vld = 1'b0;
                s_lat = '0;
                for (int i = NUM_CORES - 1; i >= 0; i--) begin
                    s_vld = on_lvl[i] ? 1'b1 : s_vld;
                    s_lat = on_lvl[i] ? lat[i] : s_lat;
                end
                diff = $signed({16'b0, s_lat}) - $signed({1'b0, avg_q});
                step = diff >>> AVG_SHIFT;
            end
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i || clear_counters_i) begin
                    avg_q  <= '0;
                    seen_q <= 1'b0;
                end else if (monitor_enable_i && s_vld) begin
                    avg_q  <= seen_q ? avg_q + step[31:0] : {15'b0, s_lat};
                    seen_q <= 1'b1;
                end
            end
            assign avg_latencies_o[l] = avg_q;
`else
            assign avg_latencies_o[l] = '0;
`endif
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_counters_i) begin
            viol_q <= '0;
            req_q  <= '0;
            err_q  <= 1'b0;
        end else if (monitor_enable_i) begin
            viol_q <= sat_add(viol_q, popcnt(miss));
            req_q  <= sat_add(req_q, popcnt(issue));
            err_q  <= err_q || (|err);
        end
    end

    assign qos_violations_o = viol_q;
    assign total_requests_o = req_q;
    assign protocol_err_o   = err_q;
endmodule

// File: tb/tb_qos_latency_monitor.sv
// tb_qos_latency_monitor: directed scoreboard bench for qos_latency_monitor.
module tb_qos_latency_monitor;
    logic             clk_i = 1'b0, rst_i = 1'b1;
    logic [3:0]       req_fire_i = '0, rsp_fire_i = '0;
    logic [3:0][3:0]  qos_level_i = '0;
    logic [3:0][15:0] latency_limit_i = '0;
    logic             monitor_enable_i = 1'b1, clear_counters_i = 1'b0;
    logic [31:0]      qos_violations_o, total_requests_o;
    logic [15:0][31:0] qos_hit_counts_o, qos_miss_counts_o, avg_latencies_o;
    logic [3:0]       inflight_overrun_o;
    logic             protocol_err_o;
    int               vectors = 0, miscompares = 0;

    typedef struct {string tag; int sel; int idx; logic [31:0] exp;} exp_t;
    exp_t sb[$];

    qos_latency_monitor dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_fire_i(req_fire_i), .rsp_fire_i(rsp_fire_i),
        .qos_level_i(qos_level_i), .latency_limit_i(latency_limit_i),
        .monitor_enable_i(monitor_enable_i), .clear_counters_i(clear_counters_i),
        .qos_violations_o(qos_violations_o), .total_requests_o(total_requests_o),
        .qos_hit_counts_o(qos_hit_counts_o), .qos_miss_counts_o(qos_miss_counts_o),
        .avg_latencies_o(avg_latencies_o), .inflight_overrun_o(inflight_overrun_o),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int HIT = 0, MISS = 1, AVG = 2, VIOL = 3, TOT = 4, OVR = 5, ERR = 6;

    function automatic logic [31:0] ea(input int v);
`ifdef QOS_MON_AVG_LATENCY_EN
        return 32'(v);
`else
        return 32'(v) & 32'd0;
`endif
    endfunction

    function automatic logic [31:0] obs(input int sel, input int idx);
        case (sel)
            HIT:     return qos_hit_counts_o[idx];
            MISS:    return qos_miss_counts_o[idx];
            AVG:     return avg_latencies_o[idx];
            VIOL:    return qos_violations_o;
            TOT:     return total_requests_o;
            OVR:     return 32'(inflight_overrun_o);
            default: return 32'(protocol_err_o);
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input int idx, input logic [31:0] v);
        sb.push_back('{tag, sel, idx, v});
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel, e.idx);
            vectors++;
            assert (o === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] req, input logic [3:0] rsp);
        req_fire_i = req;
        rsp_fire_i = rsp;
        idle(1);
        req_fire_i = '0;
        rsp_fire_i = '0;
    endtask

    task automatic cfg(input int c, input logic [3:0] lvl, input logic [15:0] lim);
        qos_level_i[c] = lvl;
        latency_limit_i[c] = lim;
    endtask

    task automatic txn(input int c, input int lat);
        pulse(4'(1 << c), 4'b0);
        idle(lat - 1);
        pulse(4'b0, 4'(1 << c));
    endtask

    initial begin
        idle(2);
        want("rst_viol", VIOL, 0, 0); want("rst_tot", TOT, 0, 0); want("rst_ovr", OVR, 0, 0);
        want("rst_err", ERR, 0, 0); want("rst_hit5", HIT, 5, 0); want("rst_avg7", AVG, 7, 0);
        check();
        rst_i = 1'b0;

        cfg(0, 5, 10);
        txn(0, 4);
        want("t1_hit5", HIT, 5, 1); want("t1_miss5", MISS, 5, 0); want("t1_tot", TOT, 0, 1);
        want("t1_viol", VIOL, 0, 0); want("t1_avg5", AVG, 5, ea(4));
        check();

        cfg(1, 2, 3);
        pulse(4'b0010, 4'b0);
        idle(2);
        want("t2_ovr_lo", OVR, 0, 0);
        check();
        idle(1);
        want("t2_ovr_hi", OVR, 0, 32'b0010);
        check();
        idle(2);
        pulse(4'b0, 4'b0010);
        want("t2_miss2", MISS, 2, 1); want("t2_hit2", HIT, 2, 0); want("t2_viol", VIOL, 0, 1);
        want("t2_tot", TOT, 0, 2); want("t2_ovr_end", OVR, 0, 0); want("t2_avg2", AVG, 2, ea(6));
        check();

        cfg(0, 7, 10); cfg(1, 7, 1); cfg(2, 7, 10); cfg(3, 7, 1);
        pulse(4'b0001, 4'b0);
        idle(2);
        pulse(4'b1110, 4'b0);
        idle(1);
        pulse(4'b0, 4'b1111);
        want("t3_hit7", HIT, 7, 2); want("t3_miss7", MISS, 7, 2); want("t3_viol", VIOL, 0, 3);
        want("t3_tot", TOT, 0, 6); want("t3_avg7", AVG, 7, ea(5));
        check();

        cfg(0, 4, 100);
        txn(0, 8);
        want("t4_avg4_a", AVG, 4, ea(8)); want("t4_hit4_a", HIT, 4, 1);
        check();
        txn(0, 16);
        want("t4_avg4_b", AVG, 4, ea(9)); want("t4_hit4_b", HIT, 4, 2); want("t4_tot", TOT, 0, 8);
        check();
        clear_counters_i = 1'b1;
        idle(1);
        clear_counters_i = 1'b0;
        want("clr_hit4", HIT, 4, 0); want("clr_hit7", HIT, 7, 0); want("clr_miss2", MISS, 2, 0);
        want("clr_viol", VIOL, 0, 0); want("clr_tot", TOT, 0, 0); want("clr_avg4", AVG, 4, 0);
        want("clr_avg7", AVG, 7, 0);
        check();
        txn(0, 16);
        want("clr_avg4_first", AVG, 4, ea(16)); want("clr_hit4_1", HIT, 4, 1); want("clr_tot_1", TOT, 0, 1);
        check();

        monitor_enable_i = 1'b0;
        txn(0, 4);
        want("dis_hit4", HIT, 4, 1); want("dis_tot", TOT, 0, 1); want("dis_avg4", AVG, 4, ea(16));
        check();
        monitor_enable_i = 1'b1;

        pulse(4'b0, 4'b0100);
        want("pe_rsp_idle", ERR, 0, 1); want("pe_tot_a", TOT, 0, 1); want("pe_hit4", HIT, 4, 1);
        check();
        cfg(3, 9, 100);
        pulse(4'b1000, 4'b0);
        want("pe_tot_b", TOT, 0, 2);
        check();
        pulse(4'b1000, 4'b0);
        want("pe_tot_ignored", TOT, 0, 2); want("pe_err_sticky", ERR, 0, 1);
        check();
        idle(1);
        pulse(4'b0, 4'b1000);
        want("pe_hit9", HIT, 9, 1); want("pe_avg9", AVG, 9, ea(3)); want("pe_tot_c", TOT, 0, 2);
        check();

        cfg(0, 5, 10);
        pulse(4'b0001, 4'b0);
        idle(2);
        pulse(4'b0001, 4'b0001);
        want("b2b_hit5_a", HIT, 5, 1); want("b2b_tot", TOT, 0, 4);
        check();
        idle(1);
        pulse(4'b0, 4'b0001);
        want("b2b_hit5_b", HIT, 5, 2); want("b2b_avg5", AVG, 5, ea(2));
        check();

        force dut.g_lvl[3].miss_q = 32'hFFFF_FFFE;
        #1;
        release dut.g_lvl[3].miss_q;
        want("sat_preload", MISS, 3, 32'hFFFF_FFFE);
        check();
        cfg(0, 3, 0); cfg(1, 3, 0); cfg(2, 3, 0);
        pulse(4'b0111, 4'b0);
        idle(1);
        pulse(4'b0, 4'b0111);
        want("sat_miss3", MISS, 3, 32'hFFFF_FFFF); want("sat_viol", VIOL, 0, 3); want("sat_tot", TOT, 0, 7);
        check();

        cfg(1, 1, 0);
        pulse(4'b0010, 4'b0);
        idle(2);
        want("mid_ovr", OVR, 0, 32'b0010);
        check();
        rst_i = 1'b1;
        #1;
        want("mid_viol", VIOL, 0, 0); want("mid_tot", TOT, 0, 0); want("mid_miss3", MISS, 3, 0);
        want("mid_hit5", HIT, 5, 0); want("mid_ovr0", OVR, 0, 0); want("mid_err", ERR, 0, 0);
        want("mid_avg5", AVG, 5, 0);
        check();
        idle(1);
        rst_i = 1'b0;
        pulse(4'b0, 4'b0010);
        want("post_err", ERR, 0, 1); want("post_miss1", MISS, 1, 0); want("post_viol", VIOL, 0, 0);
        check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
